// File: rtl/fpcvt_pkg.sv
// Shared constants for the pipelined two's-complement to floating-point converter.
// The parameter legality check is used at elaboration by fpcvt_pipe.
package fpcvt_pkg;

    localparam logic RND_NEAREST = 1'b0;
    localparam logic RND_TRUNC   = 1'b1;

    // The input must split exactly into a significand plus the full exponent span.
    function automatic bit fpcvt_params_legal(input int in_w, input int exp_w, input int man_w);
        return in_w == man_w + (1 << exp_w);
    endfunction

endpackage

// File: rtl/fpcvt_lzd.sv
// Leading-one detector: o_pos is the index of the highest set bit of i_vec.
// o_zero flags an all-zero vector, in which case o_pos is 0.
module fpcvt_lzd #(
    parameter int W  = 11,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  i_vec,
    output logic [PW-1:0] o_pos,
    output logic          o_zero
);

    always_comb begin
        o_pos = '0;
        // Scanning upward lets the highest set bit overwrite any lower ones.
        for (int i = 0; i < W; i++) begin
            if (i_vec[i]) o_pos = PW'(i);
        end
    end

    assign o_zero = ~|i_vec;

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage converter: sign/magnitude, normalise, round/clamp, with a global stall
// (every stage advances together) and a saturating count of delivered saturated results.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  D,
    input  logic             rnd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [MAN_W-1:0] F,
    output logic             sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             cnt_clr
);

    localparam int MW = IN_W - 1;
    localparam int PW = $clog2(MW);
    localparam logic [PW-1:0] MAN_P  = PW'(MAN_W);
    localparam logic [PW-1:0] MAN_M1 = PW'(MAN_W - 1);

    if (!fpcvt_params_legal(IN_W, EXP_W, MAN_W)) begin : g_bad_params
        $error("fpcvt_pipe: IN_W must equal MAN_W + 2**EXP_W");
    end

    logic w_adv;
    logic r_out_valid;
    assign w_adv    = ~r_out_valid | out_ready;
    assign in_ready = w_adv;

    // Stage 1: sign / magnitude. The most-negative input has no magnitude in MW bits.
    logic [MW-1:0] w_mag;
    logic          w_mneg;
    assign w_mag  = D[IN_W-1] ? (~D[MW-1:0] + 1'b1) : D[MW-1:0];
    assign w_mneg = D[IN_W-1] & ~|D[MW-1:0];

    logic          r1_valid, r1_s, r1_sat, r1_rnd;
    logic [MW-1:0] r1_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_s     <= 1'b0;
            r1_sat   <= 1'b0;
            r1_rnd   <= 1'b0;
            r1_mag   <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_s     <= D[IN_W-1];
            r1_sat   <= w_mneg;
            r1_rnd   <= rnd_mode;
            r1_mag   <= w_mag;
        end
    end

    // Stage 2: normalise. Small magnitudes pass through with E=0 and no rounding bit.
    logic [PW-1:0]    w_pos;
    logic             w_zero;
    logic [EXP_W-1:0] w_e, w_e_m1;
    logic [MAN_W-1:0] w_f;
    logic             w_rbit;

    fpcvt_lzd #(.W(MW), .PW(PW)) u_lzd (
        .i_vec  (r1_mag),
        .o_pos  (w_pos),
        .o_zero (w_zero)
    );

    assign w_e    = (w_zero || w_pos < MAN_P) ? '0 : EXP_W'(w_pos - MAN_M1);
    assign w_e_m1 = w_e - 1'b1;
    assign w_f    = MAN_W'(r1_mag >> w_e);
    assign w_rbit = (w_e != '0) & 1'(r1_mag >> w_e_m1);

    logic             r2_valid, r2_s, r2_sat, r2_rnd, r2_rbit;
    logic [EXP_W-1:0] r2_e;
    logic [MAN_W-1:0] r2_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_s     <= 1'b0;
            r2_sat   <= 1'b0;
            r2_rnd   <= 1'b0;
            r2_rbit  <= 1'b0;
            r2_e     <= '0;
            r2_f     <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_s     <= r1_s;
            r2_sat   <= r1_sat;
            r2_rnd   <= r1_rnd;
            r2_rbit  <= w_rbit;
            r2_e     <= w_e;
            r2_f     <= w_f;
        end
    end

    // Stage 3: round, renormalise on significand carry, clamp when the exponent runs out.
    logic [MAN_W:0]   w_fsum;
    logic             w_ovf, w_sat3;
    logic [EXP_W-1:0] w_e3;
    logic [MAN_W-1:0] w_f3;

    assign w_fsum = {1'b0, r2_f} + {{MAN_W{1'b0}}, (r2_rnd == RND_NEAREST) & r2_rbit};
    assign w_ovf  = w_fsum[MAN_W];
    assign w_sat3 = r2_sat | (w_ovf & (&r2_e));
    assign w_e3   = w_sat3 ? '1 : (w_ovf ? r2_e + 1'b1 : r2_e);
    assign w_f3   = w_sat3 ? '1 : (w_ovf ? {1'b1, {(MAN_W-1){1'b0}}} : w_fsum[MAN_W-1:0]);

    logic             r_s, r_sat;
    logic [EXP_W-1:0] r_e;
    logic [MAN_W-1:0] r_f;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_s         <= 1'b0;
            r_sat       <= 1'b0;
            r_e         <= '0;
            r_f         <= '0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            r_s         <= r2_s;
            r_sat       <= w_sat3;
            r_e         <= w_e3;
            r_f         <= w_f3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_out_valid && out_ready && r_sat && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign S         = r_s;
    assign E         = r_e;
    assign F         = r_f;
    assign sat       = r_sat;
    assign sat_cnt   = r_cnt;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Directed bench for fpcvt_pipe: vector table through a scoreboard queue, plus
// backpressure, counter clear/ceiling and mid-flight reset sequences.
module tb_fpcvt_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] D = '0;
    logic        rnd_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic        cnt_clr = 1'b0;

    logic        in_ready, out_valid, S, sat;
    logic [2:0]  E;
    logic [3:0]  F;
    logic [15:0] sat_cnt;

    logic        in_ready2, out_valid2, s2, sat2;
    logic [2:0]  e2;
    logic [3:0]  f2;
    logic [1:0]  sat_cnt2;

    always #5 clk = ~clk;

    fpcvt_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .D(D), .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .E(E), .F(F), .sat(sat), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    fpcvt_pipe #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .D(D), .rnd_mode(rnd_mode), .out_valid(out_valid2), .out_ready(out_ready),
        .S(s2), .E(e2), .F(f2), .sat(sat2), .sat_cnt(sat_cnt2), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [11:0] d;
        logic        rm;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic        st;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    logic [8:0] exp_q [$];
    logic [8:0] cur_exp = '0;
    logic [8:0] prev_out = '0;
    logic       prev_stalled = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_out = 0;
    int         n_stall = 0;

    function automatic logic [8:0] pk(input logic s, input logic [2:0] e, input logic [3:0] f,
                                      input logic st);
        return {s, e, f, st};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard and stall monitor; samples on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stalled = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (out_valid && !out_ready) begin
                chk("in_ready_during_stall", {31'b0, in_ready}, 32'd0);
                n_stall++;
            end
            if (prev_stalled) begin
                chk("held_valid", {31'b0, out_valid}, 32'd1);
                chk("held_data", {23'b0, S, E, F, sat}, {23'b0, prev_out});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h, expected no output", {S, E, F, sat});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("result_SEFsat", {23'b0, S, E, F, sat}, {23'b0, e});
                end
            end
            prev_stalled = out_valid && !out_ready;
            prev_out     = {S, E, F, sat};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [11:0] d, input logic rm, input logic [8:0] ex);
        int guard;
        in_valid = 1'b1;
        D        = d;
        rnd_mode = rm;
        cur_exp  = ex;
        guard    = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 50);
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(tbl[i].d, tbl[i].rm, pk(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].st));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nsat;
        int out0;
        int guard;

        tbl[0]  = '{12'h000, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0};
        tbl[1]  = '{12'h007, 1'b0, 1'b0, 3'd0, 4'h7, 1'b0};
        tbl[2]  = '{12'h0A5, 1'b0, 1'b0, 3'd4, 4'hA, 1'b0};
        tbl[3]  = '{12'hFFF, 1'b0, 1'b1, 3'd0, 4'h1, 1'b0};
        tbl[4]  = '{12'h3FF, 1'b0, 1'b0, 3'd7, 4'h8, 1'b0};
        tbl[5]  = '{12'h3FF, 1'b1, 1'b0, 3'd6, 4'hF, 1'b0};
        tbl[6]  = '{12'h7FF, 1'b0, 1'b0, 3'd7, 4'hF, 1'b1};
        tbl[7]  = '{12'h800, 1'b1, 1'b1, 3'd7, 4'hF, 1'b1};
        tbl[8]  = '{12'h7FF, 1'b1, 1'b0, 3'd7, 4'hF, 1'b0};
        tbl[9]  = '{12'h010, 1'b0, 1'b0, 3'd1, 4'h8, 1'b0};
        tbl[10] = '{12'h00F, 1'b0, 1'b0, 3'd0, 4'hF, 1'b0};
        tbl[11] = '{12'h01F, 1'b0, 1'b0, 3'd2, 4'h8, 1'b0};
        tbl[12] = '{12'hF5B, 1'b0, 1'b1, 3'd4, 4'hA, 1'b0};
        tbl[13] = '{12'h017, 1'b0, 1'b0, 3'd1, 4'hC, 1'b0};
        tbl[14] = '{12'hC00, 1'b0, 1'b1, 3'd7, 4'h8, 1'b0};
        tbl[15] = '{12'h800, 1'b0, 1'b1, 3'd7, 4'hF, 1'b1};
        tbl[16] = '{12'h2C0, 1'b0, 1'b0, 3'd6, 4'hB, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_SEFsat", {23'b0, S, E, F, sat}, 32'd0);
        chk("rst_sat_cnt", {16'b0, sat_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Vector table, back to back.
        nsat = 0;
        for (int i = 0; i < NV; i++) begin
            send_vec(i);
            if (tbl[i].st) nsat++;
        end
        wait_drain();
        chk("sat_cnt_after_table", {16'b0, sat_cnt}, 32'(nsat));

        // Clear together with a saturated handshake: clear wins.
        send(12'h800, 1'b1, pk(1'b1, 3'd7, 4'hF, 1'b1));
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 20);
        chk("clr_target_is_sat", {30'b0, out_valid, sat}, 32'd3);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr_priority", {16'b0, sat_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: 6 samples with a 4-cycle consumer stall mid-stream.
        out0    = n_out;
        n_stall = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send_vec(i);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_out_count", 32'(n_out - out0), 32'd6);
        chk("bp_stall_cycles", 32'(n_stall), 32'd4);

        // Counter ceiling: 5 saturated results on a 2-bit counter holds at 3.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send_vec(6);
        wait_drain();
        chk("sat_cnt_16b", {16'b0, sat_cnt}, 32'd5);
        chk("sat_cnt_2b_ceiling", {30'b0, sat_cnt2}, 32'd3);

        // Reset with three samples in flight.
        send_vec(2);
        send_vec(4);
        send_vec(7);
        #2;
        chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_SEFsat", {23'b0, S, E, F, sat}, 32'd0);
        chk("midrst_sat_cnt", {16'b0, sat_cnt}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        out0 = n_out;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale_valid", {31'b0, out_valid}, 32'd0);
            chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        send_vec(13);
        wait_drain();
        chk("post_rst_out_count", 32'(n_out - out0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpcvt_pipe.md
# fpcvt_pipe

Parametrised, pipelined successor to the team's combinational 12-bit two's-complement to floating-point converter. Accepts a signed linear sample D and produces sign S, exponent E and significand F such that |D| ≈ F·2^E. It adds per-transaction rounding-mode selection, saturation reporting, a saturation event counter and valid/ready flow control. It sits between the sample source and downstream compressed-sample storage.

## Interface
- IN_W, 12, input width in bits, two's complement.
- EXP_W, 3, exponent width.
- MAN_W, 4, significand width. Legal only when IN_W == MAN_W + 2^EXP_W; elaboration fails otherwise.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  D and rnd_mode are valid.
- in_ready  out  1  block accepts this cycle.
- D  in  IN_W  signed input sample.
- rnd_mode  in  1  0 = round-half-up on magnitude, 1 = truncate.
- out_valid  out  1  S, E, F and sat are valid.
- out_ready  in  1  consumer accepts.
- S  out  1  sign; 1 when D < 0.
- E  out  EXP_W  exponent.
- F  out  MAN_W  significand.
- sat  out  1  result clamped to E=max, F=all-ones.
- sat_cnt  out  CNT_W  count of saturated results delivered.
- cnt_clr  in  1  synchronous clear of sat_cnt.

## Operation
- Stage 1 (sign/magnitude): S = D[IN_W-1]; mag = |D| as IN_W-1 bits. Most-negative input (-2^(IN_W-1)) is flagged sat directly; its magnitude is not representable.
- Stage 2 (normalise): p = index of leading one of mag. If p < MAN_W: E=0, F=mag[MAN_W-1:0], rbit=0. Otherwise E=p-(MAN_W-1), F=mag[p -: MAN_W], rbit=mag[p-MAN_W].
- Stage 3 (round/clamp): when rnd_mode=0 and rbit=1, F+1. On F overflow (all-ones+1): F=1000…0, E+1. If E would exceed 2^EXP_W-1, output E=all-ones, F=all-ones, sat=1. Truncate mode never sets sat except for most-negative input.
- Zero input: S=0, E=0, F=0, sat=0.
- S is carried unchanged through rounding and saturation.
- sat_cnt increments by 1 on each output handshake (out_valid & out_ready) with sat=1. It holds at all-ones and does not wrap. cnt_clr has priority over a simultaneous increment; the result is 0.

## Timing
- Three-stage pipeline; latency 3 cycles from input handshake to out_valid when unstalled. Throughput 1 per cycle.
- Global stall: advance = !out_valid | out_ready. in_ready = advance. All stage registers load only on advance. Bubbles are not collapsed.
- While out_valid=1 and out_ready=0, S/E/F/sat are held stable.
- in_ready may depend combinationally on out_ready; no other comb path from inputs to outputs.
- Reset (asynchronous, any cycle, including mid-flight): all stage valids = 0, out_valid=0, S=0, E=0, F=0, sat=0, sat_cnt=0. In-flight samples are discarded. in_ready=1 from the first cycle after rst_n rises.

## Structure
- fpcvt_pkg holds the rounding-mode constants (RND_NEAREST=0, RND_TRUNC=1) and the legality-check function for IN_W/EXP_W/MAN_W.
- One sub-module, fpcvt_lzd: a parametrised leading-one detector (width IN_W-1) that returns p and a zero flag. It is used in stage 2.
- The stage registers and counter stay in fpcvt_pipe.

## Test plan
Default parameters, out_ready=1 unless stated. Each result appears 3 cycles after input.
- Basic values, rnd_mode=0: 0x000 -> S0 E000 F0000. 0x007 -> S0 E000 F0111. 0x0A5 -> S0 E100 F1010. 0xFFF -> S1 E000 F0001. All with sat=0.
- Rounding carry: 0x3FF with rnd_mode=0 -> S0 E111 F1000 sat0. Same input with rnd_mode=1 -> S0 E110 F1111.
- Saturation: 0x7FF with rnd_mode=0 -> E111 F1111 sat1. 0x800 -> S1 E111 F1111 sat1. After both are consumed, sat_cnt=2. cnt_clr asserted together with a third sat handshake -> sat_cnt=0.
- Backpressure: stream 6 samples back-to-back and hold out_ready=0 for 4 cycles mid-stream. Required: in_ready=0 during the hold, outputs stable, no sample lost or duplicated, output order equals input order.
- Reset mid-flight: assert rst_n=0 asynchronously with 3 samples in the pipe. Required: outputs go to 0 immediately, no stale out_valid after release, and the next sample converts correctly.
- Counter ceiling: with CNT_W=2, deliver 5 saturated results -> sat_cnt=3 (held at all-ones, no wrap).
